// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between ALU (src0) and LSU (src1).
// Optional stats counters are enabled with the WB_ARB_STATS_EN macro.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
`ifdef WB_ARB_STATS_EN
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       force_cnt,
`endif
  output logic              busy
);

  typedef enum logic {NORMAL = 1'b0, FORCE0 = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              en, s0_xfer, s1_xfer;

  always_comb begin
    en       = !rst && !hold;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    if (state_q == NORMAL) begin
      s1_ready = en && s1_valid;
      s0_ready = en && s0_valid && !s1_valid;
    end else begin
      s0_ready = en && s0_valid;
      s1_ready = en && s1_valid && !s0_valid;
    end
    s0_xfer = s0_valid && s0_ready;
    s1_xfer = s1_valid && s1_ready;

    // Hold freezes the starvation state entirely.
    starve_cnt_d = starve_cnt_q;
    if (!hold) begin
      if (s0_valid && !s0_ready)
        starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
      else
        starve_cnt_d = 4'd0;
    end

    state_d = state_q;
    if (!hold) begin
      if (state_q == NORMAL) begin
        if (starve_cnt_d >= LIMIT) state_d = FORCE0;
      end else if (s0_xfer || !s0_valid) begin
        state_d = NORMAL;
      end
    end

    // Writes to x0 are accepted but never reach the register file.
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (s1_xfer && s1_addr != '0) begin
      we_d    = 1'b1;
      waddr_d = s1_addr;
      wdata_d = s1_data;
    end else if (s0_xfer && s0_addr != '0) begin
      we_d    = 1'b1;
      waddr_d = s0_addr;
      wdata_d = s0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 4'd0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_data   = wdata_q;
  assign busy         = we_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] force_cnt_q, force_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    force_cnt_d    = force_cnt_q;
    if (s0_valid && s1_valid && !hold && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    if (state_q == NORMAL && state_d == FORCE0 && force_cnt_q != 16'hFFFF)
      force_cnt_d = force_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
      force_cnt_q    <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      force_cnt_q    <= force_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign force_cnt    = force_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1ns after posedge, outputs checked 1ns later.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        s0_valid, s1_valid;
  logic [4:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        write_enable, busy;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt, force_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
`ifdef WB_ARB_STATS_EN
    .conflict_cnt(conflict_cnt), .force_cnt(force_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag, input logic e0, input logic e1);
    chk({tag, ".s0_ready"}, {31'd0, s0_ready}, {31'd0, e0});
    chk({tag, ".s1_ready"}, {31'd0, s1_ready}, {31'd0, e1});
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd0; s0_data = 32'h0;
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h0;
    cyc(); #1;
    rdy("reset", 1'b0, 1'b0);
    chk("reset.we", {31'd0, write_enable}, 32'd0);
    chk("reset.addr", {27'd0, write_addr}, 32'd0);
    chk("reset.data", write_data, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    cyc();

    // Test 1: single s0 request
    rst = 1'b0; s1_valid = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    #1 rdy("t1.N", 1'b1, 1'b0);
    cyc(); s0_valid = 1'b0;
    #1;
    chk("t1.we", {31'd0, write_enable}, 32'd1);
    chk("t1.busy", {31'd0, busy}, 32'd1);
    chk("t1.addr", {27'd0, write_addr}, 32'd5);
    chk("t1.data", write_data, 32'hDEADBEEF);
    cyc(); #1;
    chk("t1.we_off", {31'd0, write_enable}, 32'd0);
    chk("t1.addr_hold", {27'd0, write_addr}, 32'd5);

    // Test 2: collision, s1 wins first
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h33;
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'h77;
    #1 rdy("t2.N", 1'b0, 1'b1);
    cyc(); s1_valid = 1'b0;
    #1 rdy("t2.N1", 1'b1, 1'b0);
    chk("t2.N1.addr", {27'd0, write_addr}, 32'd7);
    chk("t2.N1.data", write_data, 32'h77);
    cyc(); s0_valid = 1'b0;
    #1;
    chk("t2.N2.we", {31'd0, write_enable}, 32'd1);
    chk("t2.N2.addr", {27'd0, write_addr}, 32'd3);
    chk("t2.N2.data", write_data, 32'h33);

    // Test 3: starvation guard with s1 streaming
    cyc();
    s1_valid = 1'b1; s1_addr = 5'd9; s1_data = 32'h99;
    s0_valid = 1'b1; s0_addr = 5'd4; s0_data = 32'h44;
    #1 rdy("t3.N", 1'b0, 1'b1);
    cyc(); #1 rdy("t3.N1", 1'b0, 1'b1);
    chk("t3.N1.data", write_data, 32'h99);
    cyc(); #1 rdy("t3.N2", 1'b0, 1'b1);
    cyc(); #1 rdy("t3.N3", 1'b1, 1'b0);
    cyc(); s0_data = 32'h45;
    #1 rdy("t3.N4", 1'b0, 1'b1);
    chk("t3.N4.addr", {27'd0, write_addr}, 32'd4);
    chk("t3.N4.data", write_data, 32'h44);
    cyc(); s0_valid = 1'b0; s1_valid = 1'b0;
    #1;
    chk("t3.N5.addr", {27'd0, write_addr}, 32'd9);

    // Test 4: x0 write is accepted but suppressed
    cyc();
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1;
    #1 rdy("t4.N", 1'b0, 1'b1);
    cyc(); s1_valid = 1'b0;
    #1;
    chk("t4.we", {31'd0, write_enable}, 32'd0);
    chk("t4.addr", {27'd0, write_addr}, 32'd9);
    chk("t4.data", write_data, 32'h99);

    // Test 5a: one denial, then hold must freeze the starvation count at 1
    cyc();
    s0_valid = 1'b1; s0_addr = 5'd6; s0_data = 32'h66;
    s1_valid = 1'b1; s1_addr = 5'd8; s1_data = 32'h88;
    #1 rdy("t5.A", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); hold = 1'b1;
      #1 rdy($sformatf("t5.hold%0d", i), 1'b0, 1'b0);
      chk($sformatf("t5.hold%0d.we", i), {31'd0, write_enable}, (i == 0) ? 32'd1 : 32'd0);
    end
    cyc(); hold = 1'b0;
    #1 rdy("t5.B", 1'b0, 1'b1);
    chk("t5.B.we", {31'd0, write_enable}, 32'd0);
    cyc(); #1 rdy("t5.C", 1'b0, 1'b1);
    cyc(); #1 rdy("t5.D", 1'b1, 1'b0);

    // Test 5b: reset drops a registered write
    cyc();
    s0_valid = 1'b0; s1_valid = 1'b1; s1_addr = 5'd12; s1_data = 32'h12;
    #1 rdy("t5.E", 1'b0, 1'b1);
    cyc(); rst = 1'b1; s0_valid = 1'b1;
    #1 rdy("t5.E1", 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    #1;
    chk("t5.E2.we", {31'd0, write_enable}, 32'd0);
    chk("t5.E2.addr", {27'd0, write_addr}, 32'd0);
    rdy("t5.E2", 1'b0, 1'b1);
    cyc(); s0_valid = 1'b0; s1_valid = 1'b0;

`ifdef WB_ARB_STATS_EN
    // Test 6: stats counters over 10 contention cycles
    rst = 1'b1;
    cyc(); rst = 1'b0;
    #1;
    chk("t6.conf0", {16'd0, conflict_cnt}, 32'd0);
    chk("t6.force0", {16'd0, force_cnt}, 32'd0);
    s0_valid = 1'b1; s0_addr = 5'd2; s0_data = 32'h22;
    s1_valid = 1'b1; s1_addr = 5'd1; s1_data = 32'h11;
    for (int i = 0; i < 10; i++) cyc();
    s0_valid = 1'b0; s1_valid = 1'b0;
    #1;
    chk("t6.conflict", {16'd0, conflict_cnt}, 32'd10);
    chk("t6.force", {16'd0, force_cnt}, 32'd2);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: src0 (ALU) and src1 (LSU/load return).
- Each requester uses a valid/ready handshake. At most one transfer per cycle.
- The granted write is registered and drives the register file write port one cycle later.
- Fixed priority favours src1. A starvation guard forces a src0 grant after a bounded wait.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (32 registers).
- STARVE_LIMIT, 3, consecutive denied cycles of a valid src0 before src0 is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  freeze: both readys forced low, no grants.
- s0_valid  in  1  ALU writeback request.
- s0_addr  in  ADDR_W  ALU destination register.
- s0_data  in  DATA_W  ALU result.
- s0_ready  out  1  ALU request accepted this cycle (combinational).
- s1_valid  in  1  LSU writeback request.
- s1_addr  in  ADDR_W  LSU destination register.
- s1_data  in  DATA_W  load data.
- s1_ready  out  1  LSU request accepted this cycle (combinational).
- write_enable  out  1  register file write enable (registered).
- write_addr  out  ADDR_W  register file write address (registered).
- write_data  out  DATA_W  register file write data (registered).
- busy  out  1  registered write in flight this cycle, i.e. equals write_enable.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - write_enable=0, write_addr=0, write_data=0.
  - FSM=NORMAL, starve_cnt=0.
  - s0_ready/s1_ready are combinational and are 0 whenever rst=1.
- A transfer occurs when sX_valid && sX_ready.
- The readys are mutually exclusive and never depend on each other. Each is a function of valid, hold, rst and FSM state only.
- FSM, 2 states:
  - NORMAL: s1 wins if s1_valid; else s0 wins if s0_valid.
  - FORCE0: s0 wins if s0_valid; else s1 wins if s1_valid.
- starve_cnt (4 bits) updates each non-reset cycle:
  - If s0_valid && !s0_ready && !hold: increment, saturating at 15.
  - Else if s0 transfer or !s0_valid: clear to 0.
  - Hold cycles leave it unchanged.
- FSM transitions:
  - NORMAL -> FORCE0 when the next starve_cnt value is >= STARVE_LIMIT.
  - FORCE0 -> NORMAL on any s0 transfer, or when s0_valid=0.
- Latency: a transfer in cycle N gives write_enable=1 and the captured addr/data in cycle N+1. No transfer in N gives write_enable=0 in N+1; addr/data hold their last values.
- Register x0: a transfer with addr==0 is accepted (ready=1), but write_enable stays 0 in N+1. write_addr/write_data are not updated.
- Simultaneous valids: exactly one ready. The loser must hold valid, addr and data stable until accepted. The arbiter does not buffer losers.
- hold=1: both readys=0. In the next cycle, write_enable=0. FSM and starve_cnt are unchanged.
- rst asserted while a write is registered: that write is dropped. write_enable=0 in the following cycle.
- Same-address writes on consecutive cycles are issued in grant order. Ordering between sources is the caller's responsibility.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, adds ports:
  - conflict_cnt  out 16: counts cycles with s0_valid && s1_valid && !hold; saturates at 16'hFFFF.
  - force_cnt  out 16: counts entries into FORCE0; saturates at 16'hFFFF.
  - Both counters reset to 0 on rst.
- When undefined: neither port nor its logic exists, and the behaviour above is otherwise identical.

Test Plan:
1. Reset, then single request: rst high 2 cycles, then s0_valid=1, s0_addr=5, s0_data=32'hDEADBEEF for 1 cycle -> s0_ready=1 that cycle; next cycle write_enable=1, write_addr=5, write_data=32'hDEADBEEF; the cycle after, write_enable=0.
2. Collision priority: s0 (addr 3) and s1 (addr 7) valid together in cycle N -> N: s1_ready=1, s0_ready=0. N+1: write_addr=7, s0_ready=1. N+2: write_addr=3.
3. Starvation: s1_valid held high continuously, s0_valid high from cycle N, STARVE_LIMIT=3 -> s0 denied in N, N+1, N+2; s0_ready=1 in N+3; FSM returns to NORMAL in N+4; s1 wins again in N+4.
4. x0 suppression: s1_valid=1, s1_addr=0, s1_data=32'h1 -> s1_ready=1; next cycle write_enable=0 and write_addr/write_data unchanged from the prior write.
5. Hold and mid-operation reset: hold=1 with both valids for 4 cycles -> readys=0 and write_enable=0 throughout; starve_cnt unchanged. Then a transfer in cycle N with rst=1 in N+1 -> write_enable=0 in N+2; FSM=NORMAL.
6. With WB_ARB_STATS_EN: 10 cycles of both valid -> conflict_cnt=10 and force_cnt>=2. Build without the macro and rerun tests 1–5 -> identical results.
